// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: fetch FSM states, instruction queue entry, and
// the instruction field positions also used by the control unit.
package mips_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned QCNT_W     = 2;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order instruction queue between instruction memory and decode.
// Head lives in slot 0; flush empties the queue regardless of push/pop.
module fetch_queue
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  fetch_entry_t        push_data,
    input  logic                pop,
    input  logic                flush,
    output fetch_entry_t        head,
    output logic [QCNT_W-1:0]   count
);

    localparam logic [QCNT_W-1:0] CNT_ONE  = QCNT_W'(1);
    localparam logic [QCNT_W-1:0] CNT_FULL = QCNT_W'(2);

    fetch_entry_t slot0;
    fetch_entry_t slot1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (pop && count != '0) begin
            // Simultaneous push lands behind whatever survives the pop.
            if (push && count == CNT_ONE) begin
                slot0 <= push_data;
            end else begin
                slot0 <= slot1;
            end
            if (push && count == CNT_FULL) begin
                slot1 <= push_data;
            end
            if (!push) begin
                count <= count - CNT_ONE;
            end
        end else if (push && count != CNT_FULL) begin
            if (count == '0) begin
                slot0 <= push_data;
            end else begin
                slot1 <= push_data;
            end
            count <= count + CNT_ONE;
        end
    end

    assign head = slot0;

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: PC, instruction memory requests, 2-deep queue to decode,
// branch redirect with flush. Define FETCH_MISALIGN_CHECK_EN to trap misaligned targets.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned  DEPTH    = 2
)
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [5:0]  if_opcode,
    output logic [5:0]  if_funct,
    output logic        fetch_err
);

    localparam int unsigned OCC_W = 3;

    fetch_state_e       state;
    fetch_state_e       state_nxt;
    logic [31:0]        pc;
    logic [31:0]        req_pc;
    logic               inflight;
    logic [QCNT_W-1:0]  count;
    logic [OCC_W-1:0]   occupancy;
    logic               pop;
    logic               push;
    logic               accept;
    logic               misaligned;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;

    assign pop        = if_valid && if_ready;
    assign accept     = imem_req && imem_gnt;
    assign push       = imem_rvalid && inflight && !redirect_valid;
    assign push_entry = '{instr: imem_rdata, pc: req_pc};

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if (state == RUN && misaligned) begin
            fetch_err <= 1'b1;
        end
    end
`else
    logic redirect_lsb_unused;

    assign misaligned          = 1'b0;
    assign redirect_lsb_unused = ^redirect_pc[1:0];
    assign fetch_err           = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue only if the word could still find a slot after this cycle's pop.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    if (misaligned) begin
                        state_nxt = HALT;
                    end
                end else begin
                    imem_req = (occupancy < OCC_W'(DEPTH));
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
        if (rst) begin
            imem_req = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            inflight <= 1'b0;
            if (!misaligned) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end
        end else if (accept) begin
            pc       <= pc + 32'd4;
            req_pc   <= pc;
            inflight <= 1'b1;
        end else if (imem_rvalid) begin
            inflight <= 1'b0;
        end
    end

    fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign imem_addr = pc;
    assign if_valid  = (count != '0);
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;
    assign if_opcode = head.instr[OPCODE_MSB:OPCODE_LSB];
    assign if_funct  = head.instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the MIPS core: owns the program counter, issues word reads to instruction memory, buffers returned words in a 2-entry queue, and presents instructions with a valid/ready handshake to decode, where opcode and funct drive the control unit. Accepts a redirect from branch resolution (Branch & Zero), flushes wrong-path instructions and restarts fetch at the target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- DEPTH, 2: instruction queue depth; only 2 is supported.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request.
- imem_addr  out  32  byte address, always word aligned when imem_req=1.
- imem_gnt  in  1  request accepted this cycle when imem_req && imem_gnt.
- imem_rvalid  in  1  read data valid; exactly 1 cycle after acceptance.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  branch taken; single-cycle pulse.
- redirect_pc  in  32  branch target.
- if_valid  out  1  queue head valid.
- if_ready  in  1  decode accepts the head.
- if_instr  out  32  head instruction.
- if_pc  out  32  head instruction's address.
- if_opcode  out  6  if_instr[31:26].
- if_funct  out  6  if_instr[5:0].
- fetch_err  out  1  misaligned redirect trap; only with FETCH_MISALIGN_CHECK_EN.

## Operation
- States: RUN, HALT. Reset enters RUN with pc=RESET_PC.
- Reset values: imem_req=0 during rst; if_valid=0, if_instr=0, if_pc=0, fetch_err=0, queue empty, inflight=0.
- pop = if_valid && if_ready. The head is removed and the next entry moves up.
- Issue condition in RUN when redirect_valid=0: imem_req = (count + inflight - pop) < DEPTH. This is a combinational path from if_ready.
- imem_addr = pc. On acceptance: pc <= pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0). inflight <= 1, and the request's PC is captured for the response.
- Response: on imem_rvalid with inflight=1, push {rdata, captured pc}. imem_rvalid with inflight=0 is ignored.
- Redirect cycle:
  - imem_req=0.
  - Queue flushed; a pop in the same cycle still counts as consumed.
  - A response arriving in the same cycle is discarded.
  - inflight <= 0; pc <= redirect_pc.
- Queue push and pop in the same cycle: count is unchanged and order is preserved.
- HALT: imem_req=0, queue keeps draining to decode. Exit only via rst.

## Timing
- Reset release at cycle 0: imem_req=1, addr=RESET_PC. If granted, rvalid arrives at cycle 1 and if_valid=1 at cycle 2.
- Steady state with if_ready=1 and imem_gnt=1: one instruction per cycle.
- Redirect at cycle N: new request at cycle N+1, target instruction on if_valid at cycle N+3. Penalty is 2 bubbles.
- imem_gnt=0: hold imem_addr and imem_req stable; pc does not advance.
- Mid-operation rst: immediate clear, independent of clk; the in-flight response is dropped.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0] != 0 sets fetch_err=1 (sticky until rst) and enters HALT. The queue is still flushed and pc is not updated.
- FETCH_MISALIGN_CHECK_EN not defined: fetch_err tied to 0. The low two bits of the target are forced to 0 and fetch continues; the HALT state is never entered.

## Structure
- mips_pkg holds:
  - the fetch state enum (RUN, HALT);
  - the queue entry struct {instr[31:0], pc[31:0]};
  - the OPCODE_MSB/LSB and FUNCT_MSB/LSB field constants, shared with the control unit.
- Sub-module fetch_queue: 2-entry FIFO with push, pop, flush and count outputs. The PC, issue logic and state machine stay in instr_fetch_unit.

## Test plan
- Reset release with gnt=1, rvalid=1, rdata=32'h8C08_0004 at RESET_PC -> cycle 2: if_valid=1, if_pc=0, if_opcode=6'b100011.
- Continuous stream, if_ready=1 -> if_pc sequence 0,4,8,C with one instruction per cycle and no gaps.
- if_ready=0 for 5 cycles -> queue fills to 2 and imem_req drops to 0. When ready returns, entries drain in order with no loss or duplication.
- redirect_valid with redirect_pc=0x40 while the queue holds 2 entries and a response arrives -> all dropped; next request at 0x40, if_pc=0x40 two cycles later.
- Start pc=0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With FETCH_MISALIGN_CHECK_EN, redirect_pc=0x42 -> fetch_err=1, imem_req stays 0 until rst. Without the macro, fetch continues at 0x40.
